// File: rtl/uart_pkg.sv
// Types and helpers shared by the UART message engine and its echo FIFO.
package uart_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StBanner = 2'd1,
        StWait   = 2'd2,
        StEcho   = 2'd3
    } state_e;

    function automatic int unsigned cycles_from_ms(input int unsigned clk_mhz,
                                                   input int unsigned ms);
        return clk_mhz * 1000 * ms;
    endfunction

endpackage

// File: rtl/uart_msg_engine_if.sv
// Byte handshake bundle between the message engine and the uart_rx/uart_tx pair.
interface uart_msg_engine_if;
    import uart_pkg::*;

    byte_t rx_data;
    logic  rx_data_valid;
    logic  rx_data_ready;
    byte_t tx_data;
    logic  tx_data_valid;
    logic  tx_data_ready;

    modport master (
        input  rx_data,
        input  rx_data_valid,
        input  tx_data_ready,
        output rx_data_ready,
        output tx_data,
        output tx_data_valid
    );

    modport slave (
        output rx_data,
        output rx_data_valid,
        output tx_data_ready,
        input  rx_data_ready,
        input  tx_data,
        input  tx_data_valid
    );

endinterface

// File: rtl/uart_byte_fifo.sv
// Power-of-two byte FIFO; full/empty come from the occupancy counter, pointers wrap.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned PtrW = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  byte_t         wdata_i,
    input  logic          pop_i,
    output byte_t         rdata_o,
    output logic [PtrW:0] level_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam logic [PtrW:0] LevelFull = (PtrW + 1)'(DEPTH);

    byte_t           mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   level_q, level_d;
    logic            do_push, do_pop;

    assign full_o  = (level_q == LevelFull);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop frees the slot the push lands in, so a full FIFO still accepts it.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (do_pop && !do_push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/uart_msg_engine.sv
// Periodic banner transmitter plus an rx->tx echo path buffered through a byte FIFO.
module uart_msg_engine
    import uart_pkg::*;
#(
    parameter int unsigned          CLK_FRE    = 27,
    parameter int unsigned          PERIOD_MS  = 1000,
    parameter int unsigned          MSG_LEN    = 21,
    parameter logic [MSG_LEN*8-1:0] MSG        = {"Hello Tang Nano 20K", 16'h0d0a},
    parameter int unsigned          FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    uart_msg_engine_if.master           bus,
    input  logic                        banner_en,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [7:0]                  overflow_cnt
);

    localparam int unsigned P      = cycles_from_ms(CLK_FRE, PERIOD_MS);
    localparam int unsigned TimerW = $clog2(P);
    localparam int unsigned IdxW   = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    localparam logic [TimerW-1:0] TimerMax = TimerW'(P - 1);
    localparam logic [IdxW-1:0]   LastIdx  = IdxW'(MSG_LEN - 1);

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [TimerW-1:0] timer_q, timer_d, timer_inc;
    byte_t             tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        ovf_q, ovf_d;

    logic  hs, pop, push, drop;
    byte_t fifo_head;
    logic  fifo_full, fifo_empty;

    function automatic byte_t msg_byte(input logic [IdxW-1:0] i);
        return MSG[8 * (MSG_LEN - 1 - 32'(i)) +: 8];
    endfunction

    assign hs        = tx_valid_q && bus.tx_data_ready;
    assign timer_inc = (timer_q == TimerMax) ? timer_q : timer_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        pop        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (banner_en) begin
                    state_d    = StBanner;
                    tx_data_d  = msg_byte('0);
                    tx_valid_d = 1'b1;
                end else begin
                    state_d = StWait;
                end
            end
            StBanner: begin
                // banner_en is ignored here so a started message always completes
                if (hs) begin
                    if (idx_q == LastIdx) begin
                        idx_d      = '0;
                        timer_d    = '0;
                        tx_valid_d = 1'b0;
                        state_d    = StWait;
                    end else begin
                        idx_d     = idx_q + 1'b1;
                        tx_data_d = msg_byte(idx_q + 1'b1);
                    end
                end
            end
            StWait: begin
                timer_d = timer_inc;
                if (!fifo_empty) begin
                    state_d    = StEcho;
                    tx_data_d  = fifo_head;
                    tx_valid_d = 1'b1;
                end else if (timer_q == TimerMax && banner_en) begin
                    state_d    = StBanner;
                    tx_data_d  = msg_byte('0);
                    tx_valid_d = 1'b1;
                end
            end
            StEcho: begin
                timer_d = timer_inc;
                if (hs) begin
                    pop        = 1'b1;
                    tx_valid_d = 1'b0;
                    state_d    = StWait;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign push = bus.rx_data_valid && (!fifo_full || pop);
    assign drop = bus.rx_data_valid && fifo_full && !pop;

    always_comb begin
        ovf_d = ovf_q;
        if (drop && ovf_q != 8'hff) begin
            ovf_d = ovf_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            timer_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            ovf_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            ovf_q      <= ovf_d;
        end
    end

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .wdata_i (bus.rx_data),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.rx_data_ready = 1'b1;
    assign bus.tx_data       = tx_data_q;
    assign bus.tx_data_valid = tx_valid_q;
    assign overflow_cnt      = ovf_q;

endmodule

// File: doc/uart_msg_engine.md
# uart_msg_engine

Byte-level UART traffic controller: periodically transmits a parameterised banner message and echoes every received byte through an internal FIFO. Successor to the fixed "Hello" test top; received bytes are buffered instead of lost when they arrive during a banner. Sits between the existing `uart_rx` and `uart_tx` instances and connects to their byte handshake ports.

## Interface
- `CLK_FRE`, 27: clock frequency in MHz.
- `PERIOD_MS`, 1000: banner repeat period in ms. Period `P = CLK_FRE*1000*PERIOD_MS` cycles; requires `P >= 2`.
- `MSG_LEN`, 21: banner length in bytes; requires `MSG_LEN >= 1`.
- `MSG`, `{"Hello Tang Nano 20K", 16'h0d0a}`: packed banner, `MSG_LEN*8` bits. First byte sent is `MSG[MSG_LEN*8-1 -: 8]`.
- `FIFO_DEPTH`, 16: echo FIFO depth; power of two, `>= 2`.
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte.
- `rx_data_valid`  in  1  one-cycle strobe: `rx_data` is valid.
- `rx_data_ready`  out  1  tied to 1.
- `tx_data`  out  8  byte to transmit.
- `tx_data_valid`  out  1  `tx_data` is valid.
- `tx_data_ready`  in  1  transmitter accepts the byte.
- `banner_en`  in  1  1 = banner plus echo; 0 = echo only.
- `fifo_level`  out  `$clog2(FIFO_DEPTH)+1`  current FIFO occupancy.
- `overflow_cnt`  out  8  count of dropped rx bytes; saturates at 255.

## Operation
- Reset values: `tx_data = 0`, `tx_data_valid = 0`, `fifo_level = 0`, `overflow_cnt = 0`, FIFO empty, state IDLE, message index 0, timer 0.
- A handshake occurs when `tx_data_valid && tx_data_ready` at a rising edge.
- **IDLE**: after one cycle, go to BANNER if `banner_en`, otherwise go to WAIT.
- **BANNER**: present byte at index `i`. On each handshake, increment `i`. On the handshake of byte `MSG_LEN-1`: clear `i` and the timer, deassert valid, go to WAIT. Deasserting `banner_en` mid-message does not abort; the message completes.
- **WAIT**: the timer increments and saturates at `P-1`.
  - If the FIFO is non-empty, go to ECHO. Echo has priority over the banner.
  - Otherwise, if the timer is at `P-1` and `banner_en` is set, go to BANNER.
- **ECHO**: present the FIFO head with valid high. On handshake, pop the FIFO, deassert valid, return to WAIT. The timer keeps running during ECHO.
- **FIFO push**: on `rx_data_valid`, in any state.
  - Accepted if not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `overflow_cnt` increments, saturating.
  - Simultaneous push and pop leaves `fifo_level` unchanged.
- Pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. Full and empty are derived from `fifo_level`.

## Timing
- All outputs are registered.
- Once `tx_data_valid` is high, `tx_data` is held stable until the handshake.
- BANNER is back-to-back: valid stays high across handshakes and `tx_data` advances on the cycle after each handshake. With `tx_data_ready` held high, one byte is sent per cycle.
- Echo latency: an rx strobe at edge t makes `fifo_level` rise at t+1. `tx_data_valid` with that byte rises at t+2 if the state is WAIT. If the strobe arrives during BANNER, the byte waits for the banner to finish.
- `tx_data_valid` is low for at least one cycle between an echo byte and the next transmission.
- Banner period: the first banner follows reset after 1 cycle. Later banners start P cycles after the previous banner's last handshake, plus any echo time beyond P.
- Asserting `rst_n` low mid-transfer immediately clears all state, including FIFO contents.

## Structure
- Shared package `uart_pkg`: state enum (IDLE, BANNER, WAIT, ECHO), `byte_t`, and a function computing cycles from `CLK_FRE` and ms.
- One sub-module: `uart_byte_fifo` (parameter DEPTH, async active-low reset; ports for push, pop, data, level, full, empty).
- The FSM, timer and message indexing stay in `uart_msg_engine`.

## Test plan
- Parameters `MSG_LEN=3`, `MSG="ABC"`, `P=50` cycles, ready held 1 -> 0x41, 0x42, 0x43 on consecutive cycles after reset. Second banner starts 50 cycles after the 0x43 handshake.
- `banner_en=0`, rx strobe with 0x5A -> `tx_data=0x5A` with valid at +2 cycles. `fifo_level` goes 0 -> 1 -> 0. No banner ever appears.
- Rx 0x31, 0x32 mid-banner with ready toggling 1/0 -> banner completes intact and in order, then 0x31 and 0x32 are echoed. Data stays stable while ready is 0.
- `FIFO_DEPTH=4`, ready held 0, 6 rx bytes -> `fifo_level=4`, `overflow_cnt=2`. Releasing ready echoes only the first 4 bytes in order.
- Full FIFO with a pop and push in the same cycle -> push accepted, `overflow_cnt` unchanged, level stays at 4.
- Reset asserted mid-banner with FIFO at 2 -> all outputs return to reset values immediately. After release, the banner restarts from byte 0.
